// File: rtl/dmem_mmio_pkg.sv
// Shared constants and address-decode helper for the dmem_mmio data memory system.
// The timer block is built only when DMEM_TIMER_EN is defined.
package dmem_mmio_pkg;

  // Peripheral block base address and register offsets (word aligned)
  localparam logic [31:0] MMIO_BASE     = 32'h8000_0000;
  localparam logic [31:0] GPIO_OUT_OFS  = 32'h0000_0000;
  localparam logic [31:0] GPIO_IN_OFS   = 32'h0000_0004;
  localparam logic [31:0] TIMER_OFS     = 32'h0000_0008;
  localparam logic [31:0] TIMER_CMP_OFS = 32'h0000_000C;
  localparam logic [31:0] STATUS_OFS    = 32'h0000_0010;

  // Compare register comes out of reset at all-ones so a fresh timer does not
  // match until it has counted through the whole range.
  localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

  // True when a byte address hits the given peripheral register; bits [1:0]
  // are masked so every byte lane of the word selects the register.
  function automatic logic mmio_hit(input logic [31:0] addr, input logic [31:0] ofs);
    return (addr & 32'hFFFF_FFFC) == (MMIO_BASE + ofs);
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running 32-bit timer with compare register and sticky match flag.
// Instantiated by dmem_mmio only when DMEM_TIMER_EN is defined.
module mmio_timer
  import dmem_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cnt_we,
  input  logic [31:0] cnt_wdata,
  input  logic        cmp_we,
  input  logic [31:0] cmp_wdata,
  input  logic        irq_clr,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic        irq
);

  // Counter: a store replaces the increment for that cycle; wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (cnt_we) begin
      count <= cnt_wdata;
    end else begin
      count <= count + 32'd1;
    end
  end

  // Compare register, plain read/write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp <= TIMER_CMP_RST;
    end else if (cmp_we) begin
      cmp <= cmp_wdata;
    end
  end

  // Sticky flag: match uses the pre-increment count; a match beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (count == cmp) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory for the single-cycle core: word RAM plus a small MMIO block
// (GPIO out, synchronized GPIO in, optional timer under DMEM_TIMER_EN).
// Loads are combinational; stores land on the rising clock edge.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int GPIO_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MemWrite,
  input  logic [31:0]       ALUResult,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]       mem [DEPTH_WORDS];
  logic [AW-1:0]     ram_idx;
  logic              ram_sel;
  logic              sel_gpio_out;
  logic              sel_gpio_in;
  logic [GPIO_W-1:0] gpio_sync1;
  logic [GPIO_W-1:0] gpio_sync2;
  logic              unused_bits;

  assign ram_idx      = ALUResult[AW+1:2];
  assign ram_sel      = (ALUResult[31:AW+2] == '0);
  assign sel_gpio_out = mmio_hit(ALUResult, GPIO_OUT_OFS);
  assign sel_gpio_in  = mmio_hit(ALUResult, GPIO_IN_OFS);

  // Byte-offset bits and, without the timer, upper store-data bits have no use.
  assign unused_bits = ^{ALUResult[1:0], WriteData};

  // RAM store: not reset, but a store in a cycle where reset is held is dropped.
  always_ff @(posedge clk) begin
    if (reset_n && MemWrite && ram_sel) begin
      mem[ram_idx] <= WriteData;
    end
  end

  // GPIO output register keeps the low GPIO_W bits of the store data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpio_out <= '0;
    end else if (MemWrite && sel_gpio_out) begin
      gpio_out <= WriteData[GPIO_W-1:0];
    end
  end

  // Two-flop synchronizer for the asynchronous GPIO inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
    end else begin
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
    end
  end

`ifdef DMEM_TIMER_EN
  logic        sel_timer;
  logic        sel_cmp;
  logic        sel_status;
  logic [31:0] tmr_count;
  logic [31:0] tmr_cmp;
  logic        tmr_irq;

  assign sel_timer  = mmio_hit(ALUResult, TIMER_OFS);
  assign sel_cmp    = mmio_hit(ALUResult, TIMER_CMP_OFS);
  assign sel_status = mmio_hit(ALUResult, STATUS_OFS);

  mmio_timer u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .cnt_we    (MemWrite && sel_timer),
    .cnt_wdata (WriteData),
    .cmp_we    (MemWrite && sel_cmp),
    .cmp_wdata (WriteData),
    .irq_clr   (MemWrite && sel_status && WriteData[0]),
    .count     (tmr_count),
    .cmp       (tmr_cmp),
    .irq       (tmr_irq)
  );

  assign timer_irq = tmr_irq;
`else
  assign timer_irq = 1'b0;
`endif

  // Load mux: RAM or register value; anything unmapped reads zero.
  always_comb begin
    ReadData = '0;
    if (ram_sel) begin
      ReadData = mem[ram_idx];
    end else if (sel_gpio_out) begin
      ReadData[GPIO_W-1:0] = gpio_out;
    end else if (sel_gpio_in) begin
      ReadData[GPIO_W-1:0] = gpio_sync2;
`ifdef DMEM_TIMER_EN
    end else if (sel_timer) begin
      ReadData = tmr_count;
    end else if (sel_cmp) begin
      ReadData = tmr_cmp;
    end else if (sel_status) begin
      ReadData[0] = tmr_irq;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed stores/loads, GPIO sync latency,
// timer behaviour (when DMEM_TIMER_EN is defined) and mid-run reset.
// Valid/ready note: the DUT has no handshake; each driven cycle presents one
// address, and every expectation pushed for that cycle is consumed on its
// falling edge.
module tb_dmem_mmio;

  localparam logic [31:0] A_GOUT = 32'h8000_0000;
  localparam logic [31:0] A_GIN  = 32'h8000_0004;
  localparam logic [31:0] A_TMR  = 32'h8000_0008;
  localparam logic [31:0] A_CMP  = 32'h8000_000C;
  localparam logic [31:0] A_STS  = 32'h8000_0010;

  localparam int SEL_RD   = 0;
  localparam int SEL_GOUT = 1;
  localparam int SEL_IRQ  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  dmem_mmio #(.DEPTH_WORDS(64), .GPIO_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    MemWrite  = we;
    ALUResult = a;
    WriteData = d;
  endtask

  task automatic expect_v(input int sel, input logic [31:0] v, input string n);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    name_q.push_back(n);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    drive(1'b0, a, 32'h0);
    expect_v(SEL_RD, e, n);
  endtask

  // Scoreboard monitor: consume this cycle's expectations at the falling edge.
  logic [31:0] mon_exp;
  logic [31:0] mon_act;
  int          mon_sel;
  string       mon_name;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_sel  = sel_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = '0;
      case (mon_sel)
        SEL_RD:   mon_act = ReadData;
        SEL_GOUT: mon_act[7:0] = gpio_out;
        default:  mon_act[0] = timer_irq;
      endcase
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", mon_name, mon_act, mon_exp);
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    MemWrite  = 1'b0;
    ALUResult = '0;
    WriteData = '0;
    gpio_in   = '0;

    // Reset state
    rd(A_GOUT, 32'h0, "rst0_gpio_rd");
    expect_v(SEL_GOUT, 32'h0, "rst0_gpio_pin");
    expect_v(SEL_IRQ, 32'h0, "rst0_irq");
    rd(A_GIN, 32'h0, "rst0_gin");
    rd(A_TMR, 32'h0, "rst0_tmr");
`ifdef DMEM_TIMER_EN
    rd(A_CMP, 32'hFFFF_FFFF, "rst0_cmp");
`else
    rd(A_CMP, 32'h0, "rst0_cmp");
`endif
    rd(A_STS, 32'h0, "rst0_sts");
    drive(1'b0, 32'h0, 32'h0);
    reset_n = 1'b1;

    // RAM
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_load");
    rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_low_bits");
    wr(32'h0000_0000, 32'h1111_1111);
    wr(32'h0000_1000, 32'h1234_5678);
    expect_v(SEL_RD, 32'h0, "unmapped_rd_during_wr");
    rd(32'h0000_1000, 32'h0, "ram_high_unmapped");
    rd(32'h0000_0000, 32'h1111_1111, "ram_no_alias");
    wr(32'h0000_0014, 32'hCAFE_F00D);
    drive(1'b1, 32'h0000_0010, 32'h0BAD_F00D);
    expect_v(SEL_RD, 32'hDEAD_BEEF, "rw_same_old");
    rd(32'h0000_0010, 32'h0BAD_F00D, "rw_same_new");
    rd(32'h0000_0014, 32'hCAFE_F00D, "ram_word5");

    // GPIO
    wr(A_GOUT, 32'h0000_01A5);
    rd(A_GOUT, 32'h0000_00A5, "gpio_readback");
    expect_v(SEL_GOUT, 32'h0000_00A5, "gpio_out_pin");
    wr(A_GIN, 32'h0000_00FF);
    rd(A_GIN, 32'h0, "gpio_in_readonly");
    wr(32'h8000_0014, 32'h0);
    rd(32'h8000_0014, 32'h0, "unmapped_mmio");
    expect_v(SEL_GOUT, 32'h0000_00A5, "gpio_kept");
    rd(A_GIN, 32'h0, "gin_edge0");
    gpio_in = 8'h3C;
    rd(A_GIN, 32'h0, "gin_edge1");
    rd(A_GIN, 32'h0000_003C, "gin_edge2");

`ifdef DMEM_TIMER_EN
    // Compare match after reset-valued compare register
    wr(A_TMR, 32'd10);
    expect_v(SEL_IRQ, 32'h0, "irq_idle");
    wr(A_CMP, 32'd20);
    expect_v(SEL_RD, 32'hFFFF_FFFF, "cmp_old_value");
    rd(A_TMR, 32'd11, "tmr_count");
    for (int i = 3; i <= 11; i++) begin
      rd(A_STS, 32'h0, "sts_before_match");
      expect_v(SEL_IRQ, 32'h0, "irq_before_match");
    end
    rd(A_STS, 32'h1, "sts_after_match");
    expect_v(SEL_IRQ, 32'h1, "irq_rise");
    wr(A_STS, 32'h0);
    expect_v(SEL_IRQ, 32'h1, "irq_held");
    wr(A_STS, 32'h1);
    expect_v(SEL_IRQ, 32'h1, "irq_w0_no_effect");
    rd(A_STS, 32'h0, "sts_w1c");
    expect_v(SEL_IRQ, 32'h0, "irq_w1c");

    // Match and clear in the same cycle: set wins
    wr(A_TMR, 32'd100);
    wr(A_CMP, 32'd102);
    rd(A_TMR, 32'd101, "tmr_101");
    wr(A_STS, 32'h1);
    rd(A_STS, 32'h1, "set_wins_sts");
    expect_v(SEL_IRQ, 32'h1, "set_wins_irq");
    wr(A_STS, 32'h1);
    rd(A_STS, 32'h0, "clear_after_set");

    // Load replaces increment; wrap through all-ones
    wr(A_TMR, 32'h1234_5678);
    rd(A_TMR, 32'h1234_5678, "tmr_load_exact");
    rd(A_TMR, 32'h1234_5679, "tmr_after_load");
    wr(A_TMR, 32'hFFFF_FFFE);
    rd(A_TMR, 32'hFFFF_FFFE, "tmr_pre_wrap");
    rd(A_TMR, 32'hFFFF_FFFF, "tmr_max");
    rd(A_TMR, 32'h0, "tmr_wrap");

    // Arm irq before the reset test
    wr(A_TMR, 32'd500);
    wr(A_CMP, 32'd502);
    drive(1'b0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 32'h0);
    rd(A_STS, 32'h1, "irq_pre_reset");
    expect_v(SEL_IRQ, 32'h1, "irq_pin_pre_reset");
`else
    // Timer absent: its addresses are unmapped
    wr(A_TMR, 32'h0000_1234);
    rd(A_TMR, 32'h0, "notmr_tmr");
    wr(A_CMP, 32'h0000_0005);
    rd(A_CMP, 32'h0, "notmr_cmp");
    rd(A_STS, 32'h0, "notmr_sts");
    expect_v(SEL_IRQ, 32'h0, "notmr_irq");
`endif

    // Mid-run reset: registers clear at once, store is lost, RAM is kept
    drive(1'b1, 32'h0000_0014, 32'h5555_5555);
    reset_n = 1'b0;
    expect_v(SEL_GOUT, 32'h0, "rst_gpio_pin");
    expect_v(SEL_IRQ, 32'h0, "rst_irq");
    expect_v(SEL_RD, 32'hCAFE_F00D, "rst_ram_rd");
    rd(A_TMR, 32'h0, "rst_tmr");
`ifdef DMEM_TIMER_EN
    rd(A_CMP, 32'hFFFF_FFFF, "rst_cmp");
`else
    rd(A_CMP, 32'h0, "rst_cmp");
`endif
    rd(A_GOUT, 32'h0, "rst_gpio_rd");
    rd(A_STS, 32'h0, "rst_sts");
    rd(A_GIN, 32'h0, "rst_sync");
    rd(32'h0000_0014, 32'hCAFE_F00D, "rst_store_lost");
    rd(32'h0000_0010, 32'h0BAD_F00D, "rst_ram_kept");
    drive(1'b0, 32'h0, 32'h0);
    reset_n = 1'b1;
    rd(32'h0000_0000, 32'h1111_1111, "post_rst_ram");

    // Final report
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory system for the single-cycle RISC-V core. It consumes the core's `MemWrite`, `ALUResult` (used as the address) and `WriteData`, and returns `ReadData` in the same cycle. It contains a word-addressed data RAM plus a small memory-mapped peripheral block: a GPIO output register, a synchronized GPIO input, and a free-running timer with a compare interrupt.

## Interface
Parameters:
- `DEPTH_WORDS`, default 64: number of 32-bit RAM words. Must be a power of two, at least 4.
- `GPIO_W`, default 8: width of the GPIO output and input ports, 1..32.

Ports:
- `clk`  in  1: single clock. All state updates on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `MemWrite`  in  1: store strobe from the core.
- `ALUResult`  in  32: byte address. Bits [1:0] are ignored; accesses are word-only.
- `WriteData`  in  32: store data.
- `ReadData`  out  32: load data. Combinational from the address.
- `gpio_in`  in  GPIO_W: asynchronous external inputs.
- `gpio_out`  out  GPIO_W: registered output port.
- `timer_irq`  out  1: sticky compare-match flag.

## Operation
Memory map. Address bits [1:0] are ignored for every region.
- `0x0000_0000` to `DEPTH_WORDS*4-1`: RAM. The word index is `ALUResult[$clog2(DEPTH_WORDS)+1:2]`. The RAM is selected only when all higher address bits are 0.
- `0x8000_0000` GPIO_OUT: read/write. Holds the low GPIO_W bits; reads zero-extend.
- `0x8000_0004` GPIO_IN: read-only. Returns the 2-flop synchronized `gpio_in`, zero-extended. Writes are ignored.
- `0x8000_0008` TIMER: read/write, 32-bit.
- `0x8000_000C` TIMER_CMP: read/write, 32-bit.
- `0x8000_0010` STATUS: bit0 = irq pending. Writing 1 to bit0 clears it; writing 0 has no effect. All other bits read 0.
- Any other address: reads return 0, writes are ignored. No error signalling.

Reads: `ReadData` is a purely combinational mux of RAM contents and register values, and is valid in the same cycle as the address.

Writes: when `MemWrite` is 1, the selected location updates at the rising edge of `clk`.

Timer:
- TIMER increments by 1 every cycle and wraps from `0xFFFF_FFFF` to 0.
- A store to TIMER loads `WriteData` and replaces that cycle's increment; counting resumes from the loaded value on the next cycle.
- When TIMER equals TIMER_CMP (value before increment), irq pending is set on the next edge.
- If a match and a STATUS bit0 write-1 occur in the same cycle, set wins.
- `timer_irq` equals irq pending.

## Timing
- Load latency: 0 cycles (combinational).
- Store latency: visible to a read in the cycle after the edge.
- GPIO_IN latency: 2 cycles from `gpio_in` to the readable value.
- Reset values:
  - `gpio_out` = 0
  - TIMER = 0
  - TIMER_CMP = `0xFFFF_FFFF`
  - irq pending = 0
  - synchronizer flops = 0
  - RAM is not reset; its contents are undefined.
- `ReadData` follows the register reset values immediately, since it is combinational.
- If reset asserts mid-operation, all registers clear asynchronously and a store in that cycle is lost. RAM keeps its contents.
- A read and a write to the same address in the same cycle return the old value.

## Configuration
- `DMEM_TIMER_EN` defined: TIMER, TIMER_CMP, STATUS and `timer_irq` are present as described above.
- `DMEM_TIMER_EN` undefined:
  - No timer logic is synthesized.
  - Addresses `0x8000_0008` to `0x8000_0010` behave as unmapped: reads return 0, writes are ignored.
  - `timer_irq` is tied to 0.

## Structure
- Package `dmem_mmio_pkg` holds:
  - address constants: `MMIO_BASE`, `GPIO_OUT_OFS`, `GPIO_IN_OFS`, `TIMER_OFS`, `TIMER_CMP_OFS`, `STATUS_OFS`
  - `TIMER_CMP_RST` = `32'hFFFF_FFFF`
- Sub-module `mmio_timer` holds the counter, compare register and sticky flag. It takes write enables and data, and outputs the count, compare value and irq.
- `mmio_timer` is instantiated only under `DMEM_TIMER_EN`.

## Test plan
- RAM: store `0xDEADBEEF` to `0x0000_0010`, then load it; `ReadData` = `0xDEADBEEF`. Load `0x0000_0013` returns the same word. Load `0x0000_1000` returns 0.
- GPIO: store `0x1A5` to `0x8000_0000` with GPIO_W=8; `gpio_out` = `0xA5` and readback = `0x0000_00A5`. Drive `gpio_in`=`0x3C`; `0x8000_0004` reads `0x3C` from the 2nd edge after the change, not before.
- Timer wrap: store `0xFFFF_FFFE` to TIMER; two cycles later TIMER reads `0x0000_0000`.
- Compare: after reset, store TIMER_CMP=20 with TIMER=10. `timer_irq` rises exactly 10 edges later and stays high. A STATUS write of 1 clears it; a STATUS write of 0 does not.
- Simultaneous events: a W1C to STATUS in the same cycle as a match leaves `timer_irq`=1. A TIMER store in the same cycle as an increment loads `WriteData` exactly.
- Reset: assert `reset_n`=0 mid-count with `gpio_out`≠0 and irq=1. All outputs and registers read their reset values immediately, and RAM data is preserved. With `DMEM_TIMER_EN` undefined, TIMER reads 0 and `timer_irq`=0.
